// File: rtl/seq_booth_mult.sv
// seq_booth_mult: sequential radix-4 Booth multiplier.
// Produces the full 2*WIDTH-bit product of A and B, as signed or unsigned,
// in WIDTH/2+1 iteration cycles behind a start/busy/done handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       request, accepted only while busy = 0
//   signed_mode 1 = two's-complement operands, 0 = unsigned (captured with start)
//   A, B        multiplicand / multiplier (captured with start)
//   busy        high while an operation is in progress
//   done        one-cycle pulse when Result is written
//   Result      product, held until the next operation completes
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands captured on an accepted start
// CALC  | one Booth iteration per cycle, counter counts down to 1
// DONE  | Result valid, done pulse; returns to IDLE unconditionally

module seq_booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Result
);

  // Operands are widened by two bits so unsigned values look like
  // non-negative signed values and the final Booth triplet is well defined.
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [EW-1:0]   mcand;
  logic [EW-1:0]   mplr;
  logic [AW-1:0]   acc;
  logic            bm1;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   a_ext, pp, sum, acc_nx;
  logic [EW-1:0]   mplr_nx;
  logic [2:0]      trip;
  logic            last_iter;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last_iter) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One Booth step: add the recoded partial product, then shift the
  // combined {acc, mplr} pair arithmetically right by two.
  always_comb begin
    a_ext = {{2{mcand[EW-1]}}, mcand};
    trip  = {mplr[1:0], bm1};
    pp    = '0;
    case (trip)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = -(a_ext << 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
    sum     = acc + pp;
    acc_nx  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    mplr_nx = {sum[1:0], mplr[EW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      bm1    <= 1'b0;
      cnt    <= '0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{2{A[WIDTH-1] & signed_mode}}, A};
            mplr  <= {{2{B[WIDTH-1] & signed_mode}}, B};
            acc   <= '0;
            bm1   <= 1'b0;
            cnt   <= CW'(N);
          end
        end
        CALC: begin
          acc  <= acc_nx;
          mplr <= mplr_nx;
          bm1  <= mplr[1];
          cnt  <= cnt - CW'(1);
          // The low 2*WIDTH bits of {acc, mplr} after the last shift.
          if (last_iter) Result <= {acc_nx[WIDTH-3:0], mplr_nx};
        end
        default: ;
      endcase
    end
  end

endmodule
